alu_muldiv_sequencer: RTL and testbench
=======================================

Name: alu_muldiv_sequencer

Overview:
- Multi-cycle controller that drives one shared 64-bit ALU instance (AND/OR/ADD/SUB, 4-bit control) to compute unsigned 64-bit multiply (shift-add) and divide (restoring).
- Sits beside the datapath ALU and owns its operand and control inputs while busy.
- Upstream logic sees a start/busy/done handshake; the block never performs add/sub internally, only through the ALU port.

Parameters:
- WIDTH, 64, operand/result width; ALU width must match.
- ITER, 64, iterations per operation; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when state=IDLE
- op  input  1  0=multiply, 1=divide; sampled on accept
- operand_a  input  64  multiplicand / dividend; sampled on accept
- operand_b  input  64  multiplier / divisor; sampled on accept
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse, high in DONE
- result  output  64  product low 64 bits / quotient
- remainder  output  64  divide remainder; 0 after multiply
- div_by_zero  output  1  set with done when divide had operand_b=0
- alu_a  output  64  ALU first_input
- alu_b  output  64  ALU second_input
- alu_ctrl  output  4  ALU control: 0010=add, 0110=sub
- alu_res  input  64  ALU result, combinational from alu_a/alu_b/alu_ctrl

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE, iteration counter=0.
  - busy=0, done=0, result=0, remainder=0, div_by_zero=0.
  - alu_a=0, alu_b=0, alu_ctrl=0000.
  - Reset mid-RUN aborts silently; no done pulse.
- IDLE:
  - alu_a=alu_b=0, alu_ctrl=0000.
  - start=1 → latch op and operands, clear counter, clear div_by_zero.
  - Divide with operand_b=0 → go to DONE with result=all-ones, remainder=operand_a, div_by_zero=1 (latency 1).
  - Otherwise → RUN.
- RUN, multiply (internal acc, mcand, mplier; acc=0 on accept):
  - alu_a=acc, alu_b = mplier[0] ? mcand : 0, alu_ctrl=0010.
  - Each edge: acc←alu_res, mcand←mcand<<1, mplier←mplier>>1.
  - Overflow above bit 63 is discarded.
- RUN, divide (internal rem=0, quo=dividend on accept):
  - sh = {rem, quo[63]} (65 bits).
  - alu_a=sh[63:0], alu_b=divisor, alu_ctrl=0110.
  - ge = sh[64] | (sh[63:0] >= divisor), using an unsigned compare.
  - Each edge: rem ← ge ? alu_res : sh[63:0]; quo ← {quo[62:0], ge}.
- Counter increments every RUN edge; when counter=ITER-1 the next state is DONE.
- Final register update, RUN→DONE transition:
  - Multiply: result=acc_final, remainder=0.
  - Divide: result=quo_final, remainder=rem_final.
- Latency: accept edge E0; RUN edges E1..E64; done high during the cycle after E64; E65 returns to IDLE. A new start is accepted no earlier than E66 (sampled at edge E66, when IDLE).
- DONE:
  - done=1 for exactly one cycle; alu outputs 0/0/0000.
  - start in DONE is ignored.
- start while busy is ignored; operands are never resampled mid-operation.
- result, remainder and div_by_zero stay stable from DONE until the next accept.
- The op input is don't-care outside the accept cycle.
- Simultaneous rst and start: reset wins.

Test Plan:
- Multiply 7×9: start, op=0 → done exactly 65 cycles after the accept edge; result=63, remainder=0, busy low the cycle after done.
- Multiply overflow 0x8000_0000_0000_0000×2 → result=0; and 0xFFFF_FFFF_FFFF_FFFF×0xFFFF_FFFF_FFFF_FFFF → result=1.
- Divide 100/7 → result=14, remainder=2. Divide 0xFFFF_FFFF_FFFF_FFFF/1 → result=all-ones, remainder=0. Divide 0xFFFF_FFFF_FFFF_FFFF/0x8000_0000_0000_0001 → result=1, remainder=0x7FFF_FFFF_FFFF_FFFE (exercises sh[64] / ge path).
- Divide by zero, operand_a=123 → done one cycle after accept; div_by_zero=1, result=all-ones, remainder=123; the following normal op clears div_by_zero.
- Assert rst at iteration 30 of a multiply → next cycle all outputs 0, state IDLE, no done pulse; an immediate new start 10/3 gives q=3, r=1 after 65 cycles.
- Pulse start with different operands at iteration 10 and during DONE → ignored; original result unchanged; ALU monitor shows alu_ctrl=0010 for all 64 multiply cycles and 0110 for all divide cycles.

Source files
------------

// File: rtl/alu_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_sequencer
// Purpose  : Sequences a shared external ALU to do unsigned shift-add multiply
//            and restoring divide, behind a start/busy/done handshake.
// Revision : 1.0  initial release
// ============================================================================
module alu_muldiv_sequencer #(
   parameter int WIDTH = 64,
   parameter int ITER  = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_res
);

   localparam int            CW      = $clog2(ITER);
   localparam logic [CW-1:0] LAST    = CW'(ITER - 1);
   localparam logic [3:0]    ALU_NOP = 4'b0000;
   localparam logic [3:0]    ALU_ADD = 4'b0010;
   localparam logic [3:0]    ALU_SUB = 4'b0110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             op_q, op_d;
   logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
   logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, divisor_q, divisor_d;
   logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
   logic [WIDTH-1:0] result_q, result_d, remainder_q, remainder_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [3:0]       alu_ctrl_q, alu_ctrl_d;

   // Restoring-divide step: the 65-bit shifted partial remainder and its
   // "fits" decision; bit WIDTH set means it certainly exceeds the divisor.
   logic [WIDTH:0]   sh_cur;
   logic             ge;
   logic [WIDTH-1:0] sh_nxt;

   assign sh_cur = {rem_q, quo_q[WIDTH-1]};
   assign ge     = sh_cur[WIDTH] | (sh_cur[WIDTH-1:0] >= divisor_q);
   assign sh_nxt = {rem_d[WIDTH-2:0], quo_d[WIDTH-1]};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      divisor_d   = divisor_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      dbz_d       = dbz_q;
      result_d    = result_q;
      remainder_d = remainder_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d      = op;
               cnt_d     = '0;
               dbz_d     = 1'b0;
               busy_d    = 1'b1;
               acc_d     = '0;
               mcand_d   = operand_a;
               mplier_d  = operand_b;
               rem_d     = '0;
               quo_d     = operand_a;
               divisor_d = operand_b;
               if (op && (operand_b == '0)) begin
                  state_d     = S_DONE;
                  done_d      = 1'b1;
                  dbz_d       = 1'b1;
                  result_d    = '1;
                  remainder_d = operand_a;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (!op_q) begin
               acc_d    = alu_res;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
            end else begin
               rem_d = ge ? alu_res : sh_cur[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], ge};
            end
            if (cnt_q == LAST) begin
               state_d     = S_DONE;
               done_d      = 1'b1;
               result_d    = op_q ? quo_d : acc_d;
               remainder_d = op_q ? rem_d : '0;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // ALU operands are registered, so they are derived from next-state values.
      alu_a_d    = '0;
      alu_b_d    = '0;
      alu_ctrl_d = ALU_NOP;
      if (state_d == S_RUN) begin
         if (!op_d) begin
            alu_a_d    = acc_d;
            alu_b_d    = {WIDTH{mplier_d[0]}} & mcand_d;
            alu_ctrl_d = ALU_ADD;
         end else begin
            alu_a_d    = sh_nxt;
            alu_b_d    = divisor_d;
            alu_ctrl_d = ALU_SUB;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         op_q        <= 1'b0;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         divisor_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         dbz_q       <= 1'b0;
         result_q    <= '0;
         remainder_q <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_ctrl_q  <= ALU_NOP;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         divisor_q   <= divisor_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         dbz_q       <= dbz_d;
         result_q    <= result_d;
         remainder_q <= remainder_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_ctrl_q  <= alu_ctrl_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign result      = result_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_ctrl    = alu_ctrl_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_muldiv_sequencer
// Purpose  : Randomized and directed bench with an arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        rst, start, op;
   logic [63:0] operand_a, operand_b;
   logic        busy, done, div_by_zero;
   logic [63:0] result, remainder, alu_a, alu_b, alu_res;
   logic [3:0]  alu_ctrl;

   int errors = 0;
   int checks = 0;

   alu_muldiv_sequencer #(.WIDTH(64), .ITER(64)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_ctrl    (alu_ctrl),
      .alu_res     (alu_res)
   );

   always #5 clk = ~clk;

   // Shared datapath ALU
   always_comb begin
      case (alu_ctrl)
         4'b0000: alu_res = alu_a & alu_b;
         4'b0001: alu_res = alu_a | alu_b;
         4'b0010: alu_res = alu_a + alu_b;
         4'b0110: alu_res = alu_a - alu_b;
         default: alu_res = '0;
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rand64();
      return {$urandom(), $urandom()};
   endfunction

   // One operation end to end; optionally pulse a spurious start at RUN
   // cycle ign_at and during the DONE cycle.
   task automatic run_op(input logic o, input logic [63:0] a, input logic [63:0] b,
                         input int ign_at, input bit ign_done);
      logic [63:0] er, erem;
      logic        edbz;
      int          elat, n, ctrl_ok;
      logic [3:0]  ectrl;
      if (o && b == 64'd0) begin
         er = '1; erem = a; edbz = 1'b1; elat = 0;
      end else if (!o) begin
         er = a * b; erem = '0; edbz = 1'b0; elat = 64;
      end else begin
         er = a / b; erem = a % b; edbz = 1'b0; elat = 64;
      end
      ectrl = o ? 4'b0110 : 4'b0010;

      op = o; operand_a = a; operand_b = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; op = ~o; operand_a = rand64(); operand_b = rand64();
      n = 0; ctrl_ok = 0;
      while (!done && n < 200) begin
         if (busy && alu_ctrl === ectrl) ctrl_ok++;
         start = (n == ign_at);
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      chk("latency", 64'(n), 64'(elat));
      chk("done_seen", {63'd0, done}, 64'd1);
      chk("busy_in_done", {63'd0, busy}, 64'd1);
      chk("result", result, er);
      chk("remainder", remainder, erem);
      chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, edbz});
      chk("alu_ctrl_run_cycles", 64'(ctrl_ok), 64'(elat));
      chk("alu_ctrl_done", {60'd0, alu_ctrl}, 64'd0);

      if (ign_done) begin
         start = 1'b1; op = ~o; operand_a = rand64(); operand_b = rand64();
      end
      @(posedge clk); #1;
      start = 1'b0;
      chk("done_one_cycle", {63'd0, done}, 64'd0);
      chk("busy_after_done", {63'd0, busy}, 64'd0);
      chk("result_stable", result, er);
      chk("remainder_stable", remainder, erem);
      chk("alu_a_idle", alu_a, 64'd0);
      chk("alu_b_idle", alu_b, 64'd0);
   endtask

   initial begin
      logic        ro;
      logic [63:0] ra, rb;
      rst = 1'b1; start = 1'b0; op = 1'b0; operand_a = '0; operand_b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_result", result, 64'd0);
      chk("rst_remainder", remainder, 64'd0);
      chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
      chk("rst_alu_a", alu_a, 64'd0);
      chk("rst_alu_b", alu_b, 64'd0);
      chk("rst_alu_ctrl", {60'd0, alu_ctrl}, 64'd0);

      // Reset wins over a simultaneous start
      start = 1'b1; operand_a = 64'd5; operand_b = 64'd5;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      chk("rst_vs_start_busy", {63'd0, busy}, 64'd0);

      run_op(1'b0, 64'd7, 64'd9, -1, 1'b0);
      run_op(1'b0, 64'h8000_0000_0000_0000, 64'd2, -1, 1'b0);
      run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, -1, 1'b0);
      run_op(1'b1, 64'd100, 64'd7, -1, 1'b0);
      run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, -1, 1'b0);
      run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, -1, 1'b0);
      run_op(1'b1, 64'd123, 64'd0, -1, 1'b0);
      run_op(1'b0, 64'd5, 64'd6, -1, 1'b0);

      // Abort a multiply at iteration 30
      op = 1'b0; operand_a = 64'd1234; operand_b = 64'd5678; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
      end
      chk("abort_no_done_before", {63'd0, done}, 64'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_done", {63'd0, done}, 64'd0);
      chk("abort_result", result, 64'd0);
      chk("abort_remainder", remainder, 64'd0);
      chk("abort_alu_a", alu_a, 64'd0);
      chk("abort_alu_ctrl", {60'd0, alu_ctrl}, 64'd0);
      run_op(1'b1, 64'd10, 64'd3, -1, 1'b0);

      // Spurious starts while busy and in DONE
      run_op(1'b0, 64'd12345, 64'd678, 10, 1'b1);
      run_op(1'b1, 64'd987654321, 64'd1234, 10, 1'b1);

      for (int i = 0; i < 12; i++) begin
         ro = 1'($urandom_range(0, 1));
         ra = rand64();
         rb = rand64() >> $urandom_range(0, 63);
         if (i == 5) begin
            ro = 1'b1;
            rb = 64'd0;
         end
         run_op(ro, ra, rb, (i % 3 == 0) ? int'($urandom_range(0, 63)) : -1, (i % 4 == 1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
